// File: rtl/id_pkg.sv
// id_pkg: shared types, control encodings and ID/EX buffer field offsets for the ID stage
package id_pkg;
    localparam int DATA_W = 24;
    localparam int REG_N  = 16;
    localparam int INST_W = 32;
    localparam int BUF_W  = 123;
    typedef enum logic [1:0] {R_ALU = 2'b00, I_ALU = 2'b01, MEM = 2'b10, BR = 2'b11} inst_type_e;
    localparam int CTRL_REG_WRITE   = 0;
    localparam int CTRL_MEM_TO_REG  = 1;
    localparam int CTRL_MEM_WRITE   = 2;
    localparam int CTRL_BRANCH      = 3;
    localparam int CTRL_ALU_SRC_IMM = 4;
    localparam int OFF_COND  = 119;
    localparam int OFF_TYPE  = 117;
    localparam int OFF_CTRL  = 112;
    localparam int OFF_ALUOP = 108;
    localparam int OFF_RA    = 104;
    localparam int OFF_RD1   = 80;
    localparam int OFF_RB    = 76;
    localparam int OFF_RD2   = 52;
    localparam int OFF_RD    = 48;
    localparam int OFF_RD3   = 24;
    localparam int OFF_IMM   = 0;
    localparam logic [3:0] ALU_ADD = 4'b0010;
endpackage

// File: rtl/instruction_decode_if.sv
// instruction_decode_if: IF/ID instruction, WB write port and ID/EX buffer bundle
//   master drives en, inst, WE, Rd, WD and samples bufferOut; slave (the ID stage) the reverse
interface instruction_decode_if;
    import id_pkg::*;
    logic               en;
    logic [INST_W-1:0]  inst;
    logic               WE;
    logic [3:0]         Rd;
    logic [DATA_W-1:0]  WD;
    logic [BUF_W-1:0]   bufferOut;
    modport master (output en, inst, WE, Rd, WD, input bufferOut);
    modport slave  (input en, inst, WE, Rd, WD, output bufferOut);
endinterface

// File: rtl/register_file.sv
// register_file: 16x24 register file, three combinational reads with write-first bypass, r0 hardwired to 0
//   clk, rst (sync, active-low); we/wa/wd write port; ra/rb/rc read addresses; da/db/dc read data
module register_file
    import id_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [3:0]        wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [3:0]        ra,
    input  logic [3:0]        rb,
    input  logic [3:0]        rc,
    output logic [DATA_W-1:0] da,
    output logic [DATA_W-1:0] db,
    output logic [DATA_W-1:0] dc
);
    logic [DATA_W-1:0] mem [REG_N];

    // r0 is never bypassed, so the zero check comes first
    function automatic logic [DATA_W-1:0] rd_port(input logic [3:0] a);
        return a == 4'd0 ? '0 : (we && wa == a) ? wd : mem[a];
    endfunction

    assign da = rd_port(ra);
    assign db = rd_port(rb);
    assign dc = rd_port(rc);

    always_ff @(posedge clk)
        if (!rst) mem <= '{default: '0};
        else if (we && wa != 4'd0) mem[wa] <= wd;
endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: ID stage, decodes inst, reads operands and registers the 123-bit ID/EX bundle
//   clk, rst (sync, active-low); bus.slave carries en, inst, WB write port and bufferOut
module instruction_decode
    import id_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    instruction_decode_if.slave  bus
);
    logic [DATA_W-1:0] rd1, rd2, rd3, imm;
    logic [4:0]        ctrl;
    logic [3:0]        aluop;
    inst_type_e        typ;
    logic              nop;

    register_file u_rf (
        .clk (clk),
        .rst (rst),
        .we  (bus.WE),
        .wa  (bus.Rd),
        .wd  (bus.WD),
        .ra  (bus.inst[21:18]),
        .rb  (bus.inst[17:14]),
        .rc  (bus.inst[25:22]),
        .da  (rd1),
        .db  (rd2),
        .dc  (rd3)
    );

    assign typ = inst_type_e'(bus.inst[31:30]);
    assign nop = bus.inst == '0;

    // ctrl bits are {aluSrcImm, branch, memWrite, memToReg, regWrite}; inst[29] selects store within MEM
    always_comb begin
        ctrl  = nop ? 5'b00000 :
                typ == R_ALU ? 5'b00001 :
                typ == I_ALU ? 5'b10001 :
                typ == MEM ? (bus.inst[29] ? 5'b00100 : 5'b00011) : 5'b11000;
        aluop = nop ? 4'b0000 : (typ == MEM || typ == BR) ? ALU_ADD : bus.inst[29:26];
        imm   = typ == BR ? bus.inst[23:0] : {6'b0, bus.inst[17:0]};
    end

    always_ff @(posedge clk)
        if (!rst) bus.bufferOut <= '0;
        else if (bus.en) bus.bufferOut <= {bus.inst[29:26], bus.inst[31:30], ctrl, aluop,
                                           bus.inst[21:18], rd1, bus.inst[17:14], rd2,
                                           bus.inst[25:22], rd3, imm};
endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: scoreboard bench for the ID stage
module tb_instruction_decode;
    import id_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    instruction_decode_if bus();
    instruction_decode dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [DATA_W-1:0] mregs [REG_N];
    logic [BUF_W-1:0]  sb [$];
    logic [BUF_W-1:0]  last = '0;
    logic [BUF_W-1:0]  exp_v;
    logic [BUF_W-1:0]  held;

    function automatic logic [DATA_W-1:0] mread(input logic [3:0] a);
        if (a == 4'd0) return '0;
        if (bus.WE && bus.Rd == a) return bus.WD;
        return mregs[a];
    endfunction

    function automatic logic [BUF_W-1:0] mdecode(input logic [31:0] i);
        logic [4:0]  c;
        logic [3:0]  op;
        logic [23:0] im;
        case (i[31:30])
            2'b00:   begin c = 5'b00001; op = i[29:26]; end
            2'b01:   begin c = 5'b10001; op = i[29:26]; end
            2'b10:   begin c = i[29] ? 5'b00100 : 5'b00011; op = 4'b0010; end
            default: begin c = 5'b11000; op = 4'b0010; end
        endcase
        if (i == 32'h0) begin c = 5'b00000; op = 4'b0000; end
        im = (i[31:30] == 2'b11) ? i[23:0] : {6'b0, i[17:0]};
        return {i[29:26], i[31:30], c, op, i[21:18], mread(i[21:18]), i[17:14], mread(i[17:14]),
                i[25:22], mread(i[25:22]), im};
    endfunction

    task automatic step(input logic r, input logic e, input logic [31:0] i,
                        input logic w, input logic [3:0] a, input logic [23:0] d);
        @(negedge clk);
        rst = r; bus.en = e; bus.inst = i; bus.WE = w; bus.Rd = a; bus.WD = d;
        if (!r) last = '0;
        else if (e) last = mdecode(i);
        sb.push_back(last);
        @(posedge clk);
        if (!r) for (int k = 0; k < REG_N; k++) mregs[k] = '0;
        else if (w && a != 4'd0) mregs[a] = d;
        #1;
        exp_v = sb.pop_front();
    endtask

    task automatic test_reset;
        step(1'b0, 1'b1, 32'h204A8000, 1'b1, 4'd5, 24'h123456);
        vectors++;
        if (bus.bufferOut !== '0) begin miscompares++; $display("FAIL reset_clear: got %h want 0", bus.bufferOut); end
        step(1'b1, 1'b1, 32'h00000000, 1'b1, 4'd5, 24'h123456);
        vectors++;
        if (bus.bufferOut !== exp_v) begin miscompares++; $display("FAIL reset_first_load: got %h want %h", bus.bufferOut, exp_v); end
        step(1'b0, 1'b1, 32'h5698000F, 1'b0, 4'd0, 24'h0);
        vectors++;
        if (bus.bufferOut !== '0) begin miscompares++; $display("FAIL reset_midstream: got %h want 0", bus.bufferOut); end
        step(1'b1, 1'b1, 32'h01554000, 1'b0, 4'd0, 24'h0);
        vectors++;
        if ({bus.bufferOut[OFF_RD1 +: 24], bus.bufferOut[OFF_RD2 +: 24], bus.bufferOut[OFF_RD3 +: 24]} !== 72'h0) begin
            miscompares++; $display("FAIL reset_regs_zero: got %h want 0", bus.bufferOut);
        end
        vectors++;
        if (bus.bufferOut !== exp_v) begin miscompares++; $display("FAIL reset_regs_sb: got %h want %h", bus.bufferOut, exp_v); end
    endtask

    task automatic test_reg_alu;
        step(1'b1, 1'b1, 32'h204A8000, 1'b0, 4'd0, 24'h0);
        vectors++;
        if ({bus.bufferOut[OFF_CTRL +: 5], bus.bufferOut[OFF_ALUOP +: 4], bus.bufferOut[OFF_RA +: 4],
             bus.bufferOut[OFF_RB +: 4], bus.bufferOut[OFF_RD +: 4]} !== {5'b00001, 4'b1000, 4'b0010, 4'b1010, 4'b0001}) begin
            miscompares++; $display("FAIL reg_alu_fields: got %h want ctrl 00001 alu 8 ra 2 rb a rd 1", bus.bufferOut);
        end
        vectors++;
        if (bus.bufferOut !== exp_v) begin miscompares++; $display("FAIL reg_alu_sb: got %h want %h", bus.bufferOut, exp_v); end
    endtask

    task automatic test_imm_alu;
        step(1'b1, 1'b1, 32'h5698000F, 1'b0, 4'd0, 24'h0);
        vectors++;
        if ({bus.bufferOut[OFF_CTRL +: 5], bus.bufferOut[OFF_ALUOP +: 4], bus.bufferOut[OFF_RA +: 4],
             bus.bufferOut[OFF_RD +: 4], bus.bufferOut[OFF_IMM +: 24]} !== {5'b10001, 4'b0101, 4'b0110, 4'b1010, 24'd15}) begin
            miscompares++; $display("FAIL imm_alu_fields: got %h want ctrl 10001 alu 5 ra 6 rd a imm 15", bus.bufferOut);
        end
        vectors++;
        if (bus.bufferOut !== exp_v) begin miscompares++; $display("FAIL imm_alu_sb: got %h want %h", bus.bufferOut, exp_v); end
    endtask

    task automatic test_memory;
        step(1'b1, 1'b1, 32'h83C10000, 1'b0, 4'd0, 24'h0);
        vectors++;
        if ({bus.bufferOut[OFF_CTRL +: 5], bus.bufferOut[OFF_ALUOP +: 4], bus.bufferOut[OFF_RA +: 4],
             bus.bufferOut[OFF_RB +: 4], bus.bufferOut[OFF_RD +: 4]} !== {5'b00011, 4'b0010, 4'b0000, 4'b0100, 4'b1111}) begin
            miscompares++; $display("FAIL load_fields: got %h want ctrl 00011 alu 2 ra 0 rb 4 rd f", bus.bufferOut);
        end
        step(1'b1, 1'b1, 32'hA0440000, 1'b0, 4'd0, 24'h0);
        vectors++;
        if ({bus.bufferOut[OFF_CTRL +: 5], bus.bufferOut[OFF_ALUOP +: 4], bus.bufferOut[OFF_COND +: 4]} !== {5'b00100, 4'b0010, 4'b1000}) begin
            miscompares++; $display("FAIL store_fields: got %h want ctrl 00100 alu 2 cond 8", bus.bufferOut);
        end
        vectors++;
        if (bus.bufferOut !== exp_v) begin miscompares++; $display("FAIL store_sb: got %h want %h", bus.bufferOut, exp_v); end
    endtask

    task automatic test_branch_nop;
        step(1'b1, 1'b1, 32'hD000001A, 1'b0, 4'd0, 24'h0);
        vectors++;
        if ({bus.bufferOut[OFF_CTRL +: 5], bus.bufferOut[OFF_ALUOP +: 4], bus.bufferOut[OFF_TYPE +: 2],
             bus.bufferOut[OFF_IMM +: 24]} !== {5'b11000, 4'b0010, 2'b11, 24'd26}) begin
            miscompares++; $display("FAIL branch_fields: got %h want ctrl 11000 alu 2 type 3 imm 26", bus.bufferOut);
        end
        step(1'b1, 1'b1, 32'h00000000, 1'b0, 4'd0, 24'h0);
        vectors++;
        if ({bus.bufferOut[OFF_CTRL +: 5], bus.bufferOut[OFF_ALUOP +: 4]} !== 9'h0) begin
            miscompares++; $display("FAIL nop_fields: got %h want ctrl 0 alu 0", bus.bufferOut);
        end
    endtask

    task automatic test_bypass_stall;
        step(1'b1, 1'b1, 32'h00CC0000, 1'b1, 4'd3, 24'hABCDEF);
        vectors++;
        if ({bus.bufferOut[OFF_RD1 +: 24], bus.bufferOut[OFF_RD3 +: 24]} !== {24'hABCDEF, 24'hABCDEF}) begin
            miscompares++; $display("FAIL bypass: got %h want RD1/RD3 abcdef", bus.bufferOut);
        end
        held = bus.bufferOut;
        step(1'b1, 1'b0, 32'h5698000F, 1'b1, 4'd7, 24'h777777);
        vectors++;
        if (bus.bufferOut !== held) begin miscompares++; $display("FAIL stall_hold: got %h want %h", bus.bufferOut, held); end
        step(1'b1, 1'b1, 32'h001C0000, 1'b0, 4'd0, 24'h0);
        vectors++;
        if (bus.bufferOut[OFF_RD1 +: 24] !== 24'h777777) begin
            miscompares++; $display("FAIL stall_write: got %h want 777777", bus.bufferOut[OFF_RD1 +: 24]);
        end
        step(1'b1, 1'b1, 32'h04000000, 1'b1, 4'd0, 24'hFFFFFF);
        vectors++;
        if (bus.bufferOut[OFF_RD1 +: 24] !== 24'h0) begin
            miscompares++; $display("FAIL r0_bypass: got %h want 0", bus.bufferOut[OFF_RD1 +: 24]);
        end
        step(1'b1, 1'b1, 32'h04000000, 1'b0, 4'd0, 24'h0);
        vectors++;
        if (bus.bufferOut[OFF_RD1 +: 24] !== 24'h0) begin
            miscompares++; $display("FAIL r0_write: got %h want 0", bus.bufferOut[OFF_RD1 +: 24]);
        end
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 60; n++) begin
            step(1'b1, ($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 15)), 24'($urandom));
            vectors++;
            if (bus.bufferOut !== exp_v) begin
                miscompares++; $display("FAIL back_to_back[%0d]: got %h want %h", n, bus.bufferOut, exp_v);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < REG_N; k++) mregs[k] = '0;
        bus.en = 1'b0; bus.inst = '0; bus.WE = 1'b0; bus.Rd = '0; bus.WD = '0;
        test_reset;
        test_reg_alu;
        test_imm_alu;
        test_memory;
        test_branch_nop;
        test_bypass_stall;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
